paddle_ctrl: RTL and testbench
==============================

// Module: paddle_ctrl
// PURPOSE
// - Conditions one player's raw up/down push-buttons and turns them into a clamped paddle
//   vertical position for the VGA game core.
// - Sits between the board buttons and top_vga's renderer; one instance per player.
// - paddle_y only changes once per video frame, so the paddle never tears mid-scan.
// PARAMETERS
// - DEBOUNCE_CYCLES  250000  stable cycles required before a button change is accepted (10 ms @ 25 MHz)
// - CNT_W            18      debounce counter width; must hold DEBOUNCE_CYCLES-1
// - Y_W              10      width of paddle_y
// - Y_MIN            0       lowest allowed paddle_y (top of screen)
// - Y_MAX            420     highest allowed paddle_y (480 - paddle height 60)
// - Y_INIT           210     paddle_y after reset; must satisfy Y_MIN <= Y_INIT <= Y_MAX
// - STEP             4       pixels moved per frame while a button is held
// PORTS
// - clk          in   1    system clock (pixel clock domain)
// - rst          in   1    synchronous reset, active-high
// - btn_up       in   1    raw, asynchronous up button, active-high
// - btn_down     in   1    raw, asynchronous down button, active-high
// - frame_tick   in   1    single-cycle pulse once per frame, from the sync generator at vsync start
// - paddle_y     out  Y_W  paddle top-edge row
// - up_held      out  1    debounced up level
// - down_held    out  1    debounced down level
// BEHAVIOUR
// - One clock; reset is synchronous and active-high.
// - Reset values: paddle_y = Y_INIT, up_held = 0, down_held = 0.
//   Synchronizer flops, debounce counters and FSMs all clear to idle-low.
// - Each button passes through a 2-FF synchronizer, then a debounce FSM. FSM states:
//   - LO: stable low. Sync input 1 -> go to RISE, counter = 0.
//   - RISE: sync input 1 -> counter++; counter == DEBOUNCE_CYCLES-1 -> go to HI.
//     Sync input 0 -> back to LO.
//   - HI: stable high. Sync input 0 -> go to FALL, counter = 0.
//   - FALL: mirror of RISE; completes to LO, a bounce returns to HI.
//   - up_held/down_held = 1 in HI and FALL, 0 in LO and RISE.
//     The held level is registered, so there are no glitches.
// - Latency: a clean raw edge shows on *_held exactly 2 + DEBOUNCE_CYCLES clk edges later.
//   Any bounce shorter than DEBOUNCE_CYCLES produces no output change.
// - Movement is evaluated only in the cycle where frame_tick = 1; paddle_y updates on that edge:
//   - up_held & !down_held: paddle_y <= (paddle_y >= Y_MIN+STEP) ? paddle_y-STEP : Y_MIN
//   - down_held & !up_held: paddle_y <= (paddle_y+STEP <= Y_MAX) ? paddle_y+STEP : Y_MAX
//   - both held or neither held: hold value.
// - Clamp arithmetic is done at Y_W+1 bits so that a sum or difference never wraps.
// - Ticks are ignored while rst = 1.
// - Reset mid-debounce or mid-move discards all state; paddle_y returns to Y_INIT next edge.
// - A button change and frame_tick in the same cycle: the move uses the *_held value
//   registered before that edge (the old level).
// - Consecutive frame_ticks are legal; each tick moves by one STEP.
// STRUCTURE
// - Shared package (vga_pkg): screen constants H_ACTIVE=640, V_ACTIVE=480, PADDLE_H=60,
//   and the debounce state encoding LO/RISE/HI/FALL.
// - Sub-module btn_debounce (synchronizer + FSM + counter, params DEBOUNCE_CYCLES/CNT_W):
//   instantiated twice, for up and down.
// - Position register and clamp logic live in paddle_ctrl itself.
// TESTING
// - Bench overrides: DEBOUNCE_CYCLES=4, STEP=4, Y_MIN=0, Y_MAX=420, Y_INIT=210.
//   frame_tick pulses every 20 clk.
// - Reset: assert rst 2 cycles -> paddle_y=210, up_held=0, down_held=0.
//   Ticks with no buttons -> paddle_y stays 210.
// - Bounce: btn_up toggles 1,0,1,0 with 2-cycle pulses -> up_held stays 0 throughout.
//   Then hold high -> up_held=1 exactly 6 cycles after the final rising edge.
// - Move up/clamp: hold btn_up 60 ticks -> paddle_y falls 4 per tick, 210,206,...,2,0,
//   then stays 0. Never wraps to 1020.
// - Move down/clamp: from 418 (set up via ticks), hold btn_down -> next tick 420, then stays 420.
// - Both buttons held across 3 ticks -> paddle_y unchanged.
//   Release up only -> moves +4 per tick after debounce.
// - Reset mid-operation: rst pulsed while down_held=1 and paddle_y=300 ->
//   next cycle paddle_y=210 and down_held=0. Re-debounce is required before movement resumes.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Package    : vga_pkg
// Description: Screen constants shared by the VGA game core and the
//              encoding of the button debounce state machine.
// Revision   : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int PADDLE_H = 60;

  // Debounce FSM: LO/HI are stable levels, RISE/FALL are qualification
  // windows during which the synchronized input must stay constant.
  typedef enum logic [1:0] {
    LO   = 2'd0,
    RISE = 2'd1,
    HI   = 2'd2,
    FALL = 2'd3
  } db_state_e;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/paddle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface  : paddle_ctrl_if
// Description: Button inputs, frame strobe and paddle outputs of one player.
//   btn_up, btn_down : raw asynchronous push-buttons, active-high
//   frame_tick       : single-cycle pulse once per video frame
//   paddle_y         : paddle top-edge row (Y_W bits)
//   up_held          : debounced up level
//   down_held        : debounced down level
//   master : board / stimulus side, slave : paddle_ctrl side
// Revision   : 1.0 - initial release
// ============================================================================
interface paddle_ctrl_if #(
  parameter int Y_W = 10
);

  logic           btn_up;
  logic           btn_down;
  logic           frame_tick;
  logic [Y_W-1:0] paddle_y;
  logic           up_held;
  logic           down_held;

  modport master (
    output btn_up, btn_down, frame_tick,
    input  paddle_y, up_held, down_held
  );

  modport slave (
    input  btn_up, btn_down, frame_tick,
    output paddle_y, up_held, down_held
  );

endinterface : paddle_ctrl_if
`default_nettype wire

// File: rtl/paddle_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module     : btn_debounce
// Description: 2-FF synchronizer followed by a LO/RISE/HI/FALL debounce FSM.
//              A level change is accepted only after the synchronized input
//              has held the new value long enough; a clean raw edge appears
//              on held exactly 2 + DEBOUNCE_CYCLES clock edges later.
//   clk     : system clock
//   rst     : synchronous reset, active-high
//   btn_raw : raw asynchronous button, active-high
//   held    : registered debounced level
// Revision   : 1.0 - initial release
// ============================================================================
module btn_debounce
  import vga_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,  // must be >= 2
  parameter int CNT_W           = 18
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic btn_raw,
  output logic      held
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             held_q, held_d;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LO: begin
        if (sync2_q) begin
          state_d = RISE;
          cnt_d   = '0;
        end
      end
      RISE: begin
        if (!sync2_q) begin
          state_d = LO;
        end else begin
          // The entry cycle counts as the first stable cycle, so the
          // incremented value reaching the last count completes the window.
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_LAST) state_d = HI;
        end
      end
      HI: begin
        if (!sync2_q) begin
          state_d = FALL;
          cnt_d   = '0;
        end
      end
      FALL: begin
        if (sync2_q) begin
          state_d = HI;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_LAST) state_d = LO;
        end
      end
      default: state_d = LO;
    endcase
    // Registered from the next state so held moves on the completing edge.
    held_d = (state_d == HI) || (state_d == FALL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= LO;
      cnt_q   <= '0;
      held_q  <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
    end
  end

  assign held = held_q;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/paddle_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : paddle_ctrl
// Description: Debounces one player's up/down buttons and moves a clamped
//              paddle position by STEP once per video frame.
//   clk : system clock (pixel clock domain)
//   rst : synchronous reset, active-high
//   bus : paddle_ctrl_if.slave - buttons, frame_tick in; paddle_y and
//         debounced levels out
// Revision   : 1.0 - initial release
// ============================================================================
module paddle_ctrl
  import vga_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter int Y_W             = 10,
  parameter int Y_MIN           = 0,
  parameter int Y_MAX           = 420,
  parameter int Y_INIT          = 210,
  parameter int STEP            = 4
) (
  input  wire logic     clk,
  input  wire logic     rst,
  paddle_ctrl_if.slave  bus
);

  // One extra bit so neither the sum nor the difference can wrap.
  localparam logic [Y_W:0]   Y_MIN_E  = (Y_W+1)'(Y_MIN);
  localparam logic [Y_W:0]   Y_MAX_E  = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W:0]   STEP_E   = (Y_W+1)'(STEP);
  localparam logic [Y_W-1:0] Y_INIT_V = Y_W'(Y_INIT);

  logic           up_held;
  logic           down_held;
  logic [Y_W-1:0] paddle_y_q, paddle_y_d;
  logic [Y_W:0]   y_ext;
  logic [Y_W:0]   y_dec;
  logic [Y_W:0]   y_inc;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_up (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(bus.btn_up),
    .held   (up_held)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_down (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(bus.btn_down),
    .held   (down_held)
  );

  assign y_ext = {1'b0, paddle_y_q};
  assign y_dec = y_ext - STEP_E;
  assign y_inc = y_ext + STEP_E;

  // Uses the held levels registered before this edge, so a button change
  // coinciding with frame_tick takes effect on the next frame.
  always_comb begin
    paddle_y_d = paddle_y_q;
    if (bus.frame_tick) begin
      if (up_held && !down_held) begin
        paddle_y_d = (y_ext >= Y_MIN_E + STEP_E) ? y_dec[Y_W-1:0] : Y_MIN_E[Y_W-1:0];
      end else if (down_held && !up_held) begin
        paddle_y_d = (y_inc <= Y_MAX_E) ? y_inc[Y_W-1:0] : Y_MAX_E[Y_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      paddle_y_q <= Y_INIT_V;
    end else begin
      paddle_y_q <= paddle_y_d;
    end
  end

  assign bus.paddle_y  = paddle_y_q;
  assign bus.up_held   = up_held;
  assign bus.down_held = down_held;

endmodule : paddle_ctrl
`default_nettype wire

// File: tb/tb_paddle_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : tb_paddle_ctrl
// Description: Directed self-checking bench for paddle_ctrl with a short
//              debounce window (4 cycles) and 20-cycle frames.
// Revision   : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_paddle_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;
  int   exp_y;

  paddle_ctrl_if #(.Y_W(10)) bus ();

  paddle_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (18),
    .Y_W            (10),
    .Y_MIN          (0),
    .Y_MAX          (420),
    .Y_INIT         (210),
    .STEP           (4)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // 19 idle cycles followed by one frame_tick cycle.
  task automatic frame();
    repeat (19) step();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
  endtask

  function automatic int mv_up(input int y);
    return (y >= 4) ? y - 4 : 0;
  endfunction

  function automatic int mv_down(input int y);
    return (y + 4 <= 420) ? y + 4 : 420;
  endfunction

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst            = 1'b1;
    bus.btn_up     = 1'b0;
    bus.btn_down   = 1'b0;
    bus.frame_tick = 1'b0;
    step();
    step();
    chk("rst_paddle_y", int'(bus.paddle_y), 210);
    chk("rst_up_held", int'(bus.up_held), 0);
    chk("rst_down_held", int'(bus.down_held), 0);
    rst = 1'b0;

    // Idle frames
    for (int i = 0; i < 2; i++) begin
      frame();
      chk("idle_paddle_y", int'(bus.paddle_y), 210);
    end

    // Bounce: 2-cycle pulses never qualify
    for (int i = 0; i < 2; i++) begin
      bus.btn_up = 1'b1;
      step(); chk("bounce_up_held", int'(bus.up_held), 0);
      step(); chk("bounce_up_held", int'(bus.up_held), 0);
      bus.btn_up = 1'b0;
      step(); chk("bounce_up_held", int'(bus.up_held), 0);
      step(); chk("bounce_up_held", int'(bus.up_held), 0);
    end
    repeat (8) begin
      step(); chk("bounce_settle", int'(bus.up_held), 0);
    end

    // Clean rising edge: held exactly 6 edges later
    bus.btn_up = 1'b1;
    repeat (5) begin
      step(); chk("up_lat_early", int'(bus.up_held), 0);
    end
    step();
    chk("up_lat_exact", int'(bus.up_held), 1);

    // Move up with clamp at 0
    exp_y = 210;
    for (int i = 0; i < 60; i++) begin
      frame();
      exp_y = mv_up(exp_y);
      chk("move_up", int'(bus.paddle_y), exp_y);
    end

    bus.btn_up = 1'b0;
    repeat (8) step();
    chk("up_release", int'(bus.up_held), 0);
    frame();
    chk("no_btn_hold", int'(bus.paddle_y), 0);

    // Reset back to 210, then move down
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_paddle_y", int'(bus.paddle_y), 210);
    bus.btn_down = 1'b1;
    repeat (6) step();
    chk("down_held_on", int'(bus.down_held), 1);
    exp_y = 210;
    for (int i = 0; i < 20; i++) begin
      frame();
      exp_y = mv_down(exp_y);
      chk("move_down", int'(bus.paddle_y), exp_y);
    end

    // Both held: no movement
    bus.btn_up = 1'b1;
    repeat (6) step();
    chk("both_up_held", int'(bus.up_held), 1);
    for (int i = 0; i < 3; i++) begin
      frame();
      chk("both_hold", int'(bus.paddle_y), 290);
    end

    // Release up only: downward movement resumes, up to 418 then clamp
    bus.btn_up = 1'b0;
    repeat (6) step();
    chk("up_off", int'(bus.up_held), 0);
    for (int i = 0; i < 32; i++) begin
      frame();
      exp_y = mv_down(exp_y);
      chk("move_down2", int'(bus.paddle_y), exp_y);
    end
    chk("at_418", int'(bus.paddle_y), 418);
    frame();
    chk("clamp_420", int'(bus.paddle_y), 420);
    for (int i = 0; i < 2; i++) begin
      frame();
      chk("stay_420", int'(bus.paddle_y), 420);
    end

    // Walk up to 300, then hold down only
    bus.btn_down = 1'b0;
    bus.btn_up   = 1'b1;
    repeat (6) step();
    chk("swap_up_held", int'(bus.up_held), 1);
    chk("swap_down_held", int'(bus.down_held), 0);
    exp_y = 420;
    for (int i = 0; i < 30; i++) begin
      frame();
      exp_y = mv_up(exp_y);
    end
    chk("at_300", int'(bus.paddle_y), 300);
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b1;
    repeat (8) step();
    chk("pre_rst_down", int'(bus.down_held), 1);
    chk("pre_rst_up", int'(bus.up_held), 0);
    chk("pre_rst_y", int'(bus.paddle_y), 300);

    // Reset mid-operation, with a tick that must be ignored
    rst = 1'b1;
    bus.frame_tick = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_y", int'(bus.paddle_y), 210);
    chk("mid_rst_down", int'(bus.down_held), 0);
    // Tick right after reset: debounce not yet complete, no movement
    step();
    bus.frame_tick = 1'b0;
    chk("tick_after_rst", int'(bus.paddle_y), 210);
    repeat (4) begin
      step(); chk("redebounce_early", int'(bus.down_held), 0);
    end
    step();
    chk("redebounce_done", int'(bus.down_held), 1);
    frame();
    chk("resume_down", int'(bus.paddle_y), 214);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule : tb_paddle_ctrl
`default_nettype wire
